ps2_packet_assembler: RTL and testbench

Sits between the PS/2 byte receiver and the mouse position/click manager. It consumes the receiver's byte strobes and aligns them into 3-byte mouse packets (status, dX, dY). It sign-extends the deltas, handles overflow, filters the 0xFA command acknowledge, and recovers from lost or corrupted bytes with an inter-byte timeout. It emits one registered packet plus a one-cycle valid strobe per good packet.

---
 rtl/ps2_packet_assembler_pkg.sv | 22 ++
 rtl/ps2_packet_assembler_gap_timer.sv | 30 +++
 rtl/ps2_packet_assembler.sv | 134 +++++++++++++
 tb/tb_ps2_packet_assembler.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_packet_assembler_pkg.sv
// Shared constants for the PS/2 mouse packet path: ACK code, status bit map
// and the packet-alignment state encoding.
package ps2_packet_assembler_pkg;

  localparam logic [7:0] PS2_ACK = 8'hFA;

  localparam int BTN_L   = 0;
  localparam int BTN_R   = 1;
  localparam int BTN_M   = 2;
  localparam int ALWAYS1 = 3;
  localparam int XSIGN   = 4;
  localparam int YSIGN   = 5;
  localparam int XOVF    = 6;
  localparam int YOVF    = 7;

  typedef enum logic [1:0] {
    S_B1 = 2'd0,
    S_B2 = 2'd1,
    S_B3 = 2'd2
  } ps2_state_t;

endpackage

// File: rtl/ps2_packet_assembler_gap_timer.sv
// Inter-byte gap timer: counts while a packet is partially assembled and
// flags when the gap reaches TIMEOUT_CYCLES-1 cycles.
module ps2_gap_timer #(
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input  logic qzt_clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge qzt_clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || !run) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = run && (cnt == LAST);

endmodule

// File: rtl/ps2_packet_assembler.sv
// Aligns PS/2 receiver bytes into 3-byte mouse packets, filters command ACKs,
// and recovers from bad or missing bytes via an inter-byte timeout.
module ps2_packet_assembler
  import ps2_packet_assembler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100_000,
  parameter int SYNC_ERR_W     = 8
) (
  input  logic                  qzt_clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  rx_err,
  input  logic                  expect_ack,
  output logic                  pkt_valid,
  output logic [2:0]            buttons,
  output logic [8:0]            delta_x,
  output logic [8:0]            delta_y,
  output logic                  x_ovf,
  output logic                  y_ovf,
  output logic [7:0]            status_raw,
  output logic                  ack_seen,
  output logic [SYNC_ERR_W-1:0] sync_err
);

  function automatic logic [SYNC_ERR_W-1:0] sat_inc(input logic [SYNC_ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // An overflowed axis reports zero motion rather than a wrapped value.
  function automatic logic signed [8:0] ovf_delta(input logic sign, input logic [7:0] mag,
                                                  input logic ovf);
    return ovf ? 9'sd0 : $signed({sign, mag});
  endfunction

  ps2_state_t state_q, state_d;
  logic [7:0] stat_p0;
  logic [7:0] dx_p0;
  logic       latch_stat, latch_dx, commit_p0, ack_p0, err_inc;
  logic       tmr_clear, tmr_run, tmr_expired;

  assign tmr_run   = (state_q != S_B1);
  assign tmr_clear = rx_valid || (state_q == S_B1);

  ps2_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .qzt_clk (qzt_clk),
    .rst_n   (rst_n),
    .clear   (tmr_clear),
    .run     (tmr_run),
    .expired (tmr_expired)
  );

  always_ff @(posedge qzt_clk) begin
    if (!rst_n) state_q <= S_B1;
    else        state_q <= state_d;
  end

  // A byte arriving on the timeout cycle takes precedence over the timeout.
  always_comb begin
    state_d    = state_q;
    latch_stat = 1'b0;
    latch_dx   = 1'b0;
    commit_p0  = 1'b0;
    ack_p0     = 1'b0;
    err_inc    = 1'b0;
    if (rx_valid) begin
      if (rx_err) begin
        state_d = S_B1;
        err_inc = 1'b1;
      end else begin
        case (state_q)
          S_B1: begin
            if (expect_ack && (rx_data == PS2_ACK)) begin
              ack_p0 = 1'b1;
            end else if (rx_data[ALWAYS1]) begin
              latch_stat = 1'b1;
              state_d    = S_B2;
            end else begin
              err_inc = 1'b1;
            end
          end
          S_B2: begin
            latch_dx = 1'b1;
            state_d  = S_B3;
          end
          S_B3: begin
            commit_p0 = 1'b1;
            state_d   = S_B1;
          end
          default: state_d = S_B1;
        endcase
      end
    end else if (tmr_expired) begin
      state_d = S_B1;
      err_inc = 1'b1;
    end
  end

  // Capture stage: partial-packet bytes, no reset needed.
  always_ff @(posedge qzt_clk) begin
    if (latch_stat) stat_p0 <= rx_data;
    if (latch_dx)   dx_p0   <= rx_data;
  end

  // Output stage: registered packet, strobes and error counter.
  always_ff @(posedge qzt_clk) begin
    if (!rst_n) begin
      pkt_valid  <= 1'b0;
      ack_seen   <= 1'b0;
      buttons    <= '0;
      delta_x    <= '0;
      delta_y    <= '0;
      x_ovf      <= 1'b0;
      y_ovf      <= 1'b0;
      status_raw <= '0;
      sync_err   <= '0;
    end else begin
      pkt_valid <= commit_p0;
      ack_seen  <= ack_p0;
      if (err_inc) sync_err <= sat_inc(sync_err);
      if (commit_p0) begin
        buttons    <= {stat_p0[BTN_M], stat_p0[BTN_R], stat_p0[BTN_L]};
        delta_x    <= ovf_delta(stat_p0[XSIGN], dx_p0, stat_p0[XOVF]);
        delta_y    <= ovf_delta(stat_p0[YSIGN], rx_data, stat_p0[YOVF]);
        x_ovf      <= stat_p0[XOVF];
        y_ovf      <= stat_p0[YOVF];
        status_raw <= stat_p0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_packet_assembler.sv
// Bench for ps2_packet_assembler: directed scenarios plus randomized traffic
// against a queue-based packet model.
module tb_ps2_packet_assembler;

  localparam int TO = 40;

  logic       qzt_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_err = 1'b0;
  logic       expect_ack = 1'b0;
  logic       pkt_valid, x_ovf, y_ovf, ack_seen;
  logic [2:0] buttons;
  logic [8:0] delta_x, delta_y;
  logic [7:0] status_raw, sync_err;

  ps2_packet_assembler #(.TIMEOUT_CYCLES(TO), .SYNC_ERR_W(8)) dut (
    .qzt_clk(qzt_clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_err(rx_err), .expect_ack(expect_ack), .pkt_valid(pkt_valid),
    .buttons(buttons), .delta_x(delta_x), .delta_y(delta_y), .x_ovf(x_ovf),
    .y_ovf(y_ovf), .status_raw(status_raw), .ack_seen(ack_seen), .sync_err(sync_err)
  );

  always #10 qzt_clk = ~qzt_clk;

  int errors = 0;
  int checks = 0;

  // Reference model: bytes collected so far, idle gap, and last committed packet.
  logic [7:0] m_q[$];
  int         m_idle = 0;
  int         m_err = 0;
  logic [2:0] m_btn = '0;
  logic [8:0] m_dx = '0, m_dy = '0;
  logic       m_xo = 0, m_yo = 0;
  logic [7:0] m_raw = '0;
  int         m_pkts = 0, m_acks = 0, d_pkts = 0, d_acks = 0, pulse_off = 0;

  task automatic tick(input logic v, input logic [7:0] d, input logic e,
                      input logic a, input logic r);
    logic pe, ae;
    logic [7:0] s;
    rx_valid = v; rx_data = d; rx_err = e; expect_ack = a; rst_n = r;
    @(posedge qzt_clk);
    #1;
    pe = 0; ae = 0;
    if (!r) begin
      m_q.delete(); m_idle = 0; m_err = 0;
      m_btn = '0; m_dx = '0; m_dy = '0; m_xo = 0; m_yo = 0; m_raw = '0;
    end else if (v) begin
      m_idle = 0;
      if (e) begin
        m_q.delete();
        if (m_err < 255) m_err++;
      end else if (m_q.size() == 0) begin
        if (a && d == 8'hFA) ae = 1;
        else if (d[3]) m_q.push_back(d);
        else if (m_err < 255) m_err++;
      end else begin
        m_q.push_back(d);
        if (m_q.size() == 3) begin
          s = m_q[0];
          m_btn = s[2:0]; m_xo = s[6]; m_yo = s[7]; m_raw = s;
          m_dx = s[6] ? 9'd0 : {s[4], m_q[1]};
          m_dy = s[7] ? 9'd0 : {s[5], m_q[2]};
          m_q.delete();
          pe = 1;
        end
      end
    end else if (m_q.size() > 0) begin
      m_idle++;
      if (m_idle >= TO) begin
        m_q.delete(); m_idle = 0;
        if (m_err < 255) m_err++;
      end
    end
    m_pkts += int'(pe); m_acks += int'(ae);
    d_pkts += int'(pkt_valid === 1'b1); d_acks += int'(ack_seen === 1'b1);
    if (pkt_valid !== pe || ack_seen !== ae) pulse_off++;
    rx_valid = 0; rx_err = 0;
  endtask

  task automatic send(input logic [7:0] d, input int gap);
    tick(1, d, 0, 0, 1);
    for (int i = 0; i < gap; i++) tick(0, 8'h00, 0, 0, 1);
  endtask

  task automatic test_reset();
    tick(0, 8'h00, 0, 0, 0);
    tick(1, 8'h08, 0, 0, 0);
    checks++;
    if ({pkt_valid, buttons, delta_x, delta_y, x_ovf, y_ovf, status_raw, ack_seen, sync_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got pv=%b btn=%b dx=%h dy=%h ovf=%b%b raw=%h ack=%b se=%0d want all 0",
               pkt_valid, buttons, delta_x, delta_y, x_ovf, y_ovf, status_raw, ack_seen, sync_err);
    end
  endtask

  task automatic test_basic();
    int p0;
    p0 = d_pkts;
    send(8'h29, 4); send(8'h10, 4); tick(1, 8'hF0, 0, 0, 1);
    checks++;
    if (pkt_valid !== 1'b1) begin errors++; $display("FAIL basic_pv: got %b want 1", pkt_valid); end
    checks++;
    if ({buttons, delta_x, delta_y, x_ovf, y_ovf, status_raw} !== {3'b001, 9'h010, 9'h1F0, 2'b00, 8'h29}) begin
      errors++;
      $display("FAIL basic_pkt: got btn=%b dx=%h dy=%h ovf=%b%b raw=%h want 001 010 1f0 00 29",
               buttons, delta_x, delta_y, x_ovf, y_ovf, status_raw);
    end
    tick(0, 8'h00, 0, 0, 1);
    checks++;
    if (d_pkts - p0 !== 1) begin errors++; $display("FAIL basic_count: got %0d want 1", d_pkts - p0); end
  endtask

  task automatic test_misalign();
    logic [7:0] se0;
    se0 = sync_err;
    send(8'h10, 1); send(8'h08, 0); send(8'h01, 0); tick(1, 8'h02, 0, 0, 1);
    checks++;
    if (sync_err !== se0 + 8'd1) begin errors++; $display("FAIL misalign_err: got %0d want %0d", sync_err, se0 + 8'd1); end
    checks++;
    if ({pkt_valid, buttons, delta_x, delta_y} !== {1'b1, 3'b000, 9'h001, 9'h002}) begin
      errors++;
      $display("FAIL misalign_pkt: got pv=%b btn=%b dx=%h dy=%h want 1 000 001 002", pkt_valid, buttons, delta_x, delta_y);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] se0;
    se0 = sync_err;
    send(8'h08, 0); send(8'h05, TO - 1);
    checks++;
    if (sync_err !== se0) begin errors++; $display("FAIL timeout_early: got %0d want %0d", sync_err, se0); end
    tick(0, 8'h00, 0, 0, 1);
    checks++;
    if (sync_err !== se0 + 8'd1 || pkt_valid !== 1'b0) begin
      errors++; $display("FAIL timeout_fire: got se=%0d pv=%b want %0d 0", sync_err, pkt_valid, se0 + 8'd1);
    end
    send(8'h08, 0); send(8'h03, 0); tick(1, 8'h04, 0, 0, 1);
    checks++;
    if ({pkt_valid, delta_x, delta_y} !== {1'b1, 9'h003, 9'h004}) begin
      errors++; $display("FAIL timeout_recover: got pv=%b dx=%h dy=%h want 1 003 004", pkt_valid, delta_x, delta_y);
    end
    // Gaps of exactly TO-1 idle cycles must still assemble.
    send(8'h18, TO - 1); send(8'h07, TO - 1); tick(1, 8'h09, 0, 0, 1);
    checks++;
    if ({pkt_valid, delta_x, delta_y, sync_err} !== {1'b1, 9'h107, 9'h009, se0 + 8'd1}) begin
      errors++; $display("FAIL timeout_edge: got pv=%b dx=%h dy=%h se=%0d want 1 107 009 %0d",
                         pkt_valid, delta_x, delta_y, sync_err, se0 + 8'd1);
    end
  endtask

  task automatic test_ack();
    int p0;
    p0 = d_pkts;
    tick(1, 8'hFA, 0, 1, 1);
    checks++;
    if (ack_seen !== 1'b1 || pkt_valid !== 1'b0) begin
      errors++; $display("FAIL ack_pulse: got ack=%b pv=%b want 1 0", ack_seen, pkt_valid);
    end
    tick(0, 8'h00, 0, 1, 1);
    checks++;
    if (ack_seen !== 1'b0) begin errors++; $display("FAIL ack_width: got %b want 0", ack_seen); end
    send(8'hFA, 0); send(8'h01, 0); tick(1, 8'h02, 0, 0, 1);
    checks++;
    if ({pkt_valid, x_ovf, y_ovf, delta_x, delta_y, buttons} !== {3'b111, 9'h000, 9'h000, 3'b010}) begin
      errors++; $display("FAIL ack_ovf_pkt: got pv=%b ovf=%b%b dx=%h dy=%h btn=%b want 1 11 000 000 010",
                         pkt_valid, x_ovf, y_ovf, delta_x, delta_y, buttons);
    end
    // expect_ack is ignored mid-packet: 0xFA is plain delta data.
    tick(1, 8'h08, 0, 1, 1); tick(1, 8'hFA, 0, 1, 1); tick(1, 8'h01, 0, 1, 1);
    checks++;
    if ({pkt_valid, delta_x, delta_y} !== {1'b1, 9'h0FA, 9'h001} || d_pkts - p0 !== 2) begin
      errors++; $display("FAIL ack_middata: got pv=%b dx=%h dy=%h n=%0d want 1 0fa 001 2",
                         pkt_valid, delta_x, delta_y, d_pkts - p0);
    end
  endtask

  task automatic test_rx_err();
    logic [7:0] se0;
    logic [24:0] snap;
    se0 = sync_err;
    snap = {buttons, delta_x, delta_y, status_raw[3:0]};
    send(8'h08, 0); tick(1, 8'h11, 1, 0, 1); send(8'h22, 0);
    checks++;
    if (sync_err !== se0 + 8'd2 || {buttons, delta_x, delta_y, status_raw[3:0]} !== snap) begin
      errors++; $display("FAIL rxerr_abort: got se=%0d outs=%h want %0d %h", sync_err,
                         {buttons, delta_x, delta_y, status_raw[3:0]}, se0 + 8'd2, snap);
    end
    send(8'h08, 0); send(8'h11, 0); tick(1, 8'h33, 0, 0, 0);
    checks++;
    if ({pkt_valid, buttons, delta_x, delta_y, x_ovf, y_ovf, status_raw, sync_err} !== '0) begin
      errors++; $display("FAIL rxerr_reset: got btn=%b dx=%h dy=%h raw=%h se=%0d want 0",
                         buttons, delta_x, delta_y, status_raw, sync_err);
    end
    send(8'h08, 0); send(8'h01, 0); tick(1, 8'h01, 0, 0, 1);
    checks++;
    if ({pkt_valid, delta_x, delta_y, status_raw} !== {1'b1, 9'h001, 9'h001, 8'h08}) begin
      errors++; $display("FAIL rxerr_after: got pv=%b dx=%h dy=%h raw=%h want 1 001 001 08",
                         pkt_valid, delta_x, delta_y, status_raw);
    end
  endtask

  task automatic test_random();
    int n;
    logic [7:0] d;
    for (int i = 0; i < 3000; i++) begin
      n = $urandom_range(0, 99);
      d = ($urandom_range(0, 7) == 0) ? 8'hFA : 8'($urandom);
      if (n < 2) for (int k = 0; k < $urandom_range(TO - 3, TO + 3); k++) tick(0, 8'h00, 0, 0, 1);
      else if (n < 3) tick(0, 8'h00, 0, 0, 0);
      else if (n < 55) tick(1, d, 1'($urandom_range(0, 19) == 0), 1'($urandom), 1);
      else tick(0, 8'h00, 0, 1'($urandom), 1);
    end
    checks++;
    if (pulse_off !== 0) begin errors++; $display("FAIL random_pulses: got %0d off-cycles want 0", pulse_off); end
    checks++;
    if (d_pkts !== m_pkts || d_acks !== m_acks) begin
      errors++; $display("FAIL random_counts: got pkts=%0d acks=%0d want %0d %0d", d_pkts, d_acks, m_pkts, m_acks);
    end
    checks++;
    if ({buttons, delta_x, delta_y, x_ovf, y_ovf, status_raw, sync_err} !==
        {m_btn, m_dx, m_dy, m_xo, m_yo, m_raw, 8'(m_err)}) begin
      errors++; $display("FAIL random_state: got %h want %h",
                         {buttons, delta_x, delta_y, x_ovf, y_ovf, status_raw, sync_err},
                         {m_btn, m_dx, m_dy, m_xo, m_yo, m_raw, 8'(m_err)});
    end
  endtask

  task automatic test_back_to_back();
    int p0;
    logic [7:0] s;
    tick(0, 8'h00, 0, 0, 0);
    p0 = d_pkts;
    for (int k = 0; k < 4; k++) begin
      s = 8'h08 | 8'($urandom_range(0, 255) & 8'h37);
      send(s, 0); send(8'($urandom), 0); send(8'($urandom), 0);
    end
    tick(0, 8'h00, 0, 0, 1);
    checks++;
    if (d_pkts - p0 !== 4 || pulse_off !== 0) begin
      errors++; $display("FAIL b2b_count: got %0d off=%0d want 4 0", d_pkts - p0, pulse_off);
    end
    checks++;
    if ({delta_x, delta_y, status_raw} !== {m_dx, m_dy, m_raw}) begin
      errors++; $display("FAIL b2b_last: got %h want %h", {delta_x, delta_y, status_raw}, {m_dx, m_dy, m_raw});
    end
    for (int k = 0; k < 254; k++) send(8'h00, 0);
    checks++;
    if (sync_err !== 8'd254) begin errors++; $display("FAIL sat_before: got %0d want 254", sync_err); end
    for (int k = 0; k < 46; k++) send(8'h00, 0);
    checks++;
    if (sync_err !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d want 255", sync_err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_misalign();
    test_timeout();
    test_ack();
    test_rx_err();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
